// File: rtl/button_event_decoder_pkg.sv
// Package for button_event_decoder.
// Holds the per-button FSM state encoding, the default timing constants and a
// helper that sizes the counters.
//
// Optional feature macro: BUTTON_EVENT_DECODER_AUTO_REPEAT_EN. The package
// contents do not depend on it.

package button_event_decoder_pkg;

    // State encoding of one button channel FSM
    localparam logic [2:0] ENC_IDLE         = 3'd0;
    localparam logic [2:0] ENC_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] ENC_PRESSED      = 3'd2;
    localparam logic [2:0] ENC_HELD         = 3'd3;
    localparam logic [2:0] ENC_RELEASE_WAIT = 3'd4;

    typedef enum logic [2:0] {
        StIdle        = ENC_IDLE,
        StPressWait   = ENC_PRESS_WAIT,
        StPressed     = ENC_PRESSED,
        StHeld        = ENC_HELD,
        StReleaseWait = ENC_RELEASE_WAIT
    } btn_state_e;

    // Defaults for a 10 MHz clock: 10 ms debounce, 0.5 s hold, 100 ms repeat
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 100000;
    localparam int unsigned DEFAULT_HOLD_CYCLES     = 5000000;
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 1000000;

    // Bits needed to count 0 .. n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_event_decoder_button_channel.sv
// button_channel: one push-button, from raw pin to event pulses.
// Raw active-low input is inverted and 2-flop synchronized; a five-state FSM
// debounces presses and releases, detects a long hold and (optionally)
// generates auto-repeat pulses while held. All event outputs are registered.
//
// Optional feature macro: BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
//   defined   : repeat_pulse fires on entry to HELD and every REPEAT_CYCLES after
//   undefined : repeat_pulse is tied low and no repeat counter exists
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-high reset
//   button_n      raw asynchronous button, 0 = pressed
//   press         one-cycle pulse per accepted press
//   release_pulse one-cycle pulse per accepted release
//   held          high while in HELD
//   repeat_pulse  one-cycle auto-repeat pulse
// ("release"/"repeat" are reserved words, hence the _pulse names.)

module button_channel
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic press,
    output logic release_pulse,
    output logic held,
    output logic repeat_pulse
);

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);

    // The cycle in IDLE/PRESSED/HELD that first sees the new level counts as
    // the first stable sample, so the wait state needs DEBOUNCE_CYCLES-1 more.
    // That gives 2 (sync) + DEBOUNCE_CYCLES cycles from raw edge to pulse.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("button_channel: need DEBOUNCE_CYCLES>=2, HOLD_CYCLES>=1, REPEAT_CYCLES>=1");
    end

    // ------------------------------------------------------------------
    // Synchronizer (inverts so that 1 = pressed)
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       level;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], ~button_n};
        end
    end

    assign level = sync_q[1];

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    btn_state_e        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              from_held_q, from_held_d;  // RELEASE_WAIT return target
    logic              press_q, press_d;
    logic              release_q, release_d;

`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
    localparam int unsigned REP_W = cnt_width(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             repeat_q, repeat_d;
`endif

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        from_held_d = from_held_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        repeat_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (level) begin
                    state_d  = StPressWait;
                    db_cnt_d = '0;
                end
            end
            StPressWait: begin
                if (!level) begin
                    state_d = StIdle;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d    = StPressed;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = (&db_cnt_q) ? db_cnt_q : db_cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!level) begin
                    state_d     = StReleaseWait;
                    db_cnt_d    = '0;
                    from_held_d = 1'b0;
                end else if (hold_cnt_q >= HOLD_LAST) begin
                    state_d = StHeld;
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
`endif
                end else begin
                    hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (!level) begin
                    state_d     = StReleaseWait;
                    db_cnt_d    = '0;
                    from_held_d = 1'b1;
                end else begin
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
                    if (rep_cnt_q >= REP_LAST) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = (&rep_cnt_q) ? rep_cnt_q : rep_cnt_q + 1'b1;
                    end
`endif
                end
            end
            StReleaseWait: begin
                // A bounce back to 1 resumes where we were; hold/repeat
                // counters were frozen meanwhile, so timing carries on.
                if (level) begin
                    state_d = from_held_q ? StHeld : StPressed;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d   = StIdle;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = (&db_cnt_q) ? db_cnt_q : db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            from_held_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            from_held_q <= from_held_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign press         = press_q;
    assign release_pulse = release_q;
    assign held          = (state_q == StHeld);

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: two debounced push-buttons driving a 2-bit mode counter.
// Button 0 steps mode up, button 1 steps it down (press or auto-repeat),
// wrapping modulo 4; steps from both buttons in the same cycle cancel.
//
// Optional feature macro: BUTTON_EVENT_DECODER_AUTO_REPEAT_EN (auto-repeat
// while held; without it repeat_pulse is constant 2'b00).
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-high reset
//   buttons[1:0]  raw asynchronous push-buttons, 0 = pressed
//   press         one-cycle pulse per accepted press
//   release_pulse one-cycle pulse per accepted release
//   held          high while the button is in the held state
//   repeat_pulse  one-cycle auto-repeat pulse
//   mode          wrap-around mode counter
// ("release"/"repeat" are reserved words, hence the _pulse names.)

module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] buttons,
    output logic [1:0] press,
    output logic [1:0] release_pulse,
    output logic [1:0] held,
    output logic [1:0] repeat_pulse,
    output logic [1:0] mode
);

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_channel0 (
        .clock         (clock),
        .reset         (reset),
        .button_n      (buttons[0]),
        .press         (press[0]),
        .release_pulse (release_pulse[0]),
        .held          (held[0]),
        .repeat_pulse  (repeat_pulse[0])
    );

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_channel1 (
        .clock         (clock),
        .reset         (reset),
        .button_n      (buttons[1]),
        .press         (press[1]),
        .release_pulse (release_pulse[1]),
        .held          (held[1]),
        .repeat_pulse  (repeat_pulse[1])
    );

    // ------------------------------------------------------------------
    // Mode counter
    // ------------------------------------------------------------------
    logic       step_up, step_down;
    logic [1:0] mode_q, mode_d;

    assign step_up   = press[0] | repeat_pulse[0];
    assign step_down = press[1] | repeat_pulse[1];

    always_comb begin
        mode_d = mode_q;
        case ({step_up, step_down})
            2'b10:   mode_d = mode_q + 2'd1;
            2'b01:   mode_d = mode_q - 2'd1;
            default: mode_d = mode_q;  // idle, or both buttons cancel
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q <= 2'b00;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with DEBOUNCE=4, HOLD=20,
// REPEAT=8. Expected press/release/repeat events (kind, button, cycle) are
// queued when stimulus is driven and matched against every pulse the DUT
// emits; levels (held, mode, reset state) are checked directly.

module tb_button_event_decoder;

    localparam int unsigned DB   = 4;
    localparam int unsigned HOLD = 20;
    localparam int unsigned REP  = 8;
    localparam int          LAT  = 2 + DB;

    localparam logic [1:0] K_PRESS   = 2'd0;
    localparam logic [1:0] K_RELEASE = 2'd1;
    localparam logic [1:0] K_REPEAT  = 2'd2;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] buttons;
    logic [1:0] press, release_pulse, held, repeat_pulse, mode;

    button_event_decoder #(
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .buttons       (buttons),
        .press         (press),
        .release_pulse (release_pulse),
        .held          (held),
        .repeat_pulse  (repeat_pulse),
        .mode          (mode)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef logic [34:0] ev_t;  // {kind, button, cycle}
    ev_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_mode;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input int idx, input int at);
        exp_q.push_back({kind, idx[0], at});
    endtask

    task automatic score(input logic [1:0] kind, input int idx);
        ev_t obs;
        ev_t e;
        obs = {kind, idx[0], cyc};
        n_cmp++;
        assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_event: observed kind %0d btn %0d cycle %0d, expected none",
                   kind, idx, cyc);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            assert (obs === e) else begin
                n_err++;
                $error("FAIL event: observed kind %0d btn %0d cycle %0d, expected kind %0d btn %0d cycle %0d",
                       obs[34:33], obs[32], obs[31:0], e[34:33], e[32], e[31:0]);
            end
        end
    endtask

    // Monitor: every emitted pulse must match the head of the queue
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (press[i] === 1'b1)         score(K_PRESS, i);
            if (release_pulse[i] === 1'b1) score(K_RELEASE, i);
            if (repeat_pulse[i] === 1'b1)  score(K_REPEAT, i);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int n;
        int r;
        reset    = 1'b1;
        buttons  = 2'b11;
        exp_mode = 2'd0;
        tick(3);
        check("reset_press", int'(press), 0);
        check("reset_release", int'(release_pulse), 0);
        check("reset_held", int'(held), 0);
        check("reset_repeat", int'(repeat_pulse), 0);
        check("reset_mode", int'(mode), 0);
        reset = 1'b0;
        tick(2);

        // Button 1 short press from mode 0: wraps down to 3
        n = cyc;
        buttons[1] = 1'b0;
        expect_ev(K_PRESS, 1, n + LAT);
        tick(10);
        buttons[1] = 1'b1;
        expect_ev(K_RELEASE, 1, n + 10 + LAT);
        tick(12);
        exp_mode = exp_mode - 2'd1;
        check("mode_wrap_down", int'(mode), int'(exp_mode));

        // Button 0 low 10 / high 10: one press, one release, 3 -> 0
        n = cyc;
        buttons[0] = 1'b0;
        expect_ev(K_PRESS, 0, n + LAT);
        tick(10);
        buttons[0] = 1'b1;
        expect_ev(K_RELEASE, 0, n + 10 + LAT);
        tick(10);
        exp_mode = exp_mode + 2'd1;
        check("mode_wrap_up", int'(mode), int'(exp_mode));

        // Glitch of DEBOUNCE-1 cycles on button 1: nothing happens
        buttons[1] = 1'b0;
        tick(DB - 1);
        buttons[1] = 1'b1;
        tick(12);
        check("glitch_mode", int'(mode), int'(exp_mode));
        check("glitch_held", int'(held), 0);

        // Exactly DEBOUNCE cycles on button 0: accepted
        n = cyc;
        buttons[0] = 1'b0;
        expect_ev(K_PRESS, 0, n + LAT);
        tick(DB);
        buttons[0] = 1'b1;
        expect_ev(K_RELEASE, 0, n + DB + LAT);
        tick(12);
        exp_mode = exp_mode + 2'd1;
        check("boundary_mode", int'(mode), int'(exp_mode));

        // Both buttons together: press = 11, mode unchanged
        n = cyc;
        buttons = 2'b00;
        expect_ev(K_PRESS, 0, n + LAT);
        expect_ev(K_PRESS, 1, n + LAT);
        tick(LAT);
        check("both_press", int'(press), 3);
        tick(4);
        buttons = 2'b11;
        expect_ev(K_RELEASE, 0, n + 10 + LAT);
        expect_ev(K_RELEASE, 1, n + 10 + LAT);
        tick(10);
        check("both_mode", int'(mode), int'(exp_mode));

        // Long hold of button 0 for 60 cycles
        n = cyc;
        buttons[0] = 1'b0;
        expect_ev(K_PRESS, 0, n + LAT);
        exp_mode = exp_mode + 2'd1;
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
        // HELD processes a sampled 1 up to 2 sync + 1 cycles after the raw edge
        for (int t = n + LAT + HOLD; t < n + 60 + 3; t += REP) begin
            expect_ev(K_REPEAT, 0, t);
            exp_mode = exp_mode + 2'd1;
        end
`endif
        tick(LAT + HOLD - 1);
        check("held_before", int'(held), 0);
        tick(1);
        check("held_enter", int'(held), 1);
        tick(60 - LAT - HOLD);
        buttons[0] = 1'b1;
        expect_ev(K_RELEASE, 0, n + 60 + LAT);
        tick(10);
        check("held_exit", int'(held), 0);
        check("hold_mode", int'(mode), int'(exp_mode));

        // Reset during PRESS_WAIT discards the press
        buttons[0] = 1'b0;
        tick(4);
        reset = 1'b1;
        #1;
        check("rst_pw_press", int'(press), 0);
        check("rst_pw_mode", int'(mode), 0);
        exp_mode = 2'd0;
        tick(2);
        r = cyc;
        reset = 1'b0;
        expect_ev(K_PRESS, 0, r + LAT);
        tick(LAT + 1);
        exp_mode = exp_mode + 2'd1;
        check("rst_pw_repress_mode", int'(mode), int'(exp_mode));
        n = cyc;
        buttons[0] = 1'b1;
        expect_ev(K_RELEASE, 0, n + LAT);
        tick(10);

        // Reset while button 1 is HELD
        n = cyc;
        buttons[1] = 1'b0;
        expect_ev(K_PRESS, 1, n + LAT);
        exp_mode = exp_mode - 2'd1;
`ifdef BUTTON_EVENT_DECODER_AUTO_REPEAT_EN
        expect_ev(K_REPEAT, 1, n + LAT + HOLD);
        exp_mode = exp_mode - 2'd1;
`endif
        tick(LAT + HOLD + 2);
        check("held1", int'(held), 2);
        check("held1_mode", int'(mode), int'(exp_mode));
        reset = 1'b1;
        #1;
        check("rst_held_held", int'(held), 0);
        check("rst_held_mode", int'(mode), 0);
        check("rst_held_repeat", int'(repeat_pulse), 0);
        exp_mode = 2'd0;
        tick(3);
        r = cyc;
        reset = 1'b0;
        expect_ev(K_PRESS, 1, r + LAT);
        tick(LAT + 1);
        exp_mode = exp_mode - 2'd1;
        check("rst_held_repress_mode", int'(mode), int'(exp_mode));
        n = cyc;
        buttons[1] = 1'b1;
        expect_ev(K_RELEASE, 1, n + LAT);
        tick(10);

        for (int k = 0; k < 50 && exp_q.size() > 0; k++) tick(1);
        check("events_outstanding", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 100000, stable-input cycles required to accept a level change (10 ms at 10 MHz).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 5000000, pressed cycles before a press counts as held (0.5 s).
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 1000000, period of auto-repeat pulses while held (100 ms).
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port buttons, input, 2 bits, raw asynchronous push-buttons, active-low (0 = pressed).
REQ-007 The block SHALL have port press, output, 2 bits, one-cycle pulse per accepted press.
REQ-008 The block SHALL have port release, output, 2 bits, one-cycle pulse per accepted release.
REQ-009 The block SHALL have port held, output, 2 bits, level high while a button is in the held state.
REQ-010 The block SHALL have port repeat, output, 2 bits, one-cycle auto-repeat pulse.
REQ-011 The block SHALL have port mode, output, 2 bits, wrap-around mode counter.

Function
REQ-012 Each raw bit SHALL be inverted, then passed through a 2-flop synchronizer; the debounce logic sees only the synchronized level.
REQ-013 Each button SHALL run an independent FSM with states IDLE, PRESS_WAIT, PRESSED, HELD, RELEASE_WAIT.
REQ-014 IDLE -> PRESS_WAIT when the synchronized level is 1; the debounce counter is cleared on entry.
REQ-015 PRESS_WAIT -> PRESSED after DEBOUNCE_CYCLES consecutive cycles at 1; any 0 returns to IDLE with no pulse.
REQ-016 press[i] SHALL pulse for exactly one cycle on the PRESS_WAIT -> PRESSED transition; total latency from raw edge = 2 + DEBOUNCE_CYCLES cycles.
REQ-017 PRESSED -> HELD after HOLD_CYCLES further cycles at 1; held[i] = 1 in HELD only.
REQ-018 PRESSED or HELD -> RELEASE_WAIT when the synchronized level is 0; counter cleared.
REQ-019 RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive 0s, pulsing release[i] once; any 1 returns to the state it came from (PRESSED or HELD) with the hold/repeat counter preserved.
REQ-020 mode SHALL increment on press[0] or repeat[0] and decrement on press[1] or repeat[1], wrapping modulo 4 (3+1 = 0, 0-1 = 3).
REQ-021 Simultaneous step events on both buttons in the same cycle SHALL leave mode unchanged.
REQ-022 All counters SHALL saturate rather than wrap; press, release and repeat are never asserted in the same cycle for one button.

Reset
REQ-023 reset SHALL asynchronously force both FSMs to IDLE, clear synchronizers and counters, and drive press = release = held = repeat = 2'b00, mode = 2'b00.
REQ-024 Reset asserted mid-press SHALL discard the press; after deassertion a still-pressed button requires a full debounce and produces one new press pulse.

Configuration
REQ-025 With macro BUTTON_EVENT_DECODER_AUTO_REPEAT_EN defined, HELD SHALL pulse repeat[i] on entry to HELD and every REPEAT_CYCLES thereafter until exit.
REQ-026 Without the macro, repeat SHALL be tied to 2'b00 and the repeat counter SHALL not be built; all other behaviour is unchanged.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (3-bit localparams) and default DEBOUNCE/HOLD/REPEAT constants.
REQ-028 One sub-module, button_channel (synchronizer + FSM + counters for one button), SHALL be instantiated twice; the mode counter lives in the top.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-029 buttons[0] low for 10 cycles then high for 10 -> press[0] once at cycle 6 after edge, release[0] once, mode 0 -> 1.
REQ-030 buttons[1] glitch low for 3 cycles -> no press, no release, mode unchanged.
REQ-031 buttons[0] held low for 60 cycles with macro defined -> held[0] high, repeat pulses spaced 8 cycles, mode advances 1 per press/repeat and wraps 3 -> 0.
REQ-032 Same stimulus without macro -> held[0] high, repeat = 0, mode advances exactly 1.
REQ-033 Both buttons pressed in the same cycle -> press = 2'b11 for one cycle, mode unchanged; mode = 0 and buttons[1] pressed -> mode = 3.
REQ-034 reset asserted during PRESS_WAIT and while HELD -> all outputs 0 immediately, mode = 0, new full debounce before next press.
